elixirchip_es1_spu_op_mem_ctl: RTL
==================================

Name: elixirchip_es1_spu_op_mem_ctl

Overview:
- Initiator-side burst controller that drives elixirchip_es1_spu_op_mem_sp.
- Converts one command (base address, length, read/write) into a per-cycle address/wdata/wvalid sequence for the memory.
- Realigns the memory's LATENCY-delayed m_rdata with a valid/last stream for downstream SPU ops.
- Sits between the SPU sequencer and one single-port memory instance.

Parameters:
- LATENCY, 3, read latency of the attached memory in cke cycles (1..3).
- DATA_BITS, 8, memory word width.
- ADDR_BITS, 3, memory address width.
- LEN_BITS, 8, burst length field width; burst = s_len+1 words.
- DEVICE, "RTL", target device string, passed through.
- SIMULATION, "false", simulation switch.
- DEBUG, "false", debug switch.

Ports:
- reset  in  1  asynchronous active-high reset
- clk  in  1  clock
- cke  in  1  clock enable; 0 freezes all state, including the read pipeline
- s_start  in  1  command strobe; accepted only in IDLE
- s_write  in  1  1=write burst, 0=read burst
- s_base  in  ADDR_BITS  burst start address
- s_len  in  LEN_BITS  word count minus 1
- s_busy  out  1  high whenever state != IDLE
- s_wdata  in  DATA_BITS  write stream word
- s_wready  out  1  s_wdata consumed this cke cycle
- m_mem_addr  out  ADDR_BITS  to mem s_addr
- m_mem_wdata  out  DATA_BITS  to mem s_wdata
- m_mem_wvalid  out  1  to mem s_wvalid
- s_mem_rdata  in  DATA_BITS  from mem m_rdata
- m_rdata  out  DATA_BITS  read stream data; combinational pass-through of s_mem_rdata
- m_rvalid  out  1  read stream valid
- m_rlast  out  1  last word of the read burst
- m_done  out  1  one-cycle pulse when the burst fully completes

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - Counters, m_mem_addr, m_mem_wdata and m_mem_wvalid are 0.
  - Token pipeline is cleared.
  - m_rvalid, m_rlast and m_done are 0.
- Reset mid-burst aborts immediately. No further writes are issued and in-flight read tokens are discarded.
- cke=0: no register changes.
- All registered outputs and derived outputs hold. s_wready is forced to 0.
- State machine (each transition occurs only on a cke=1 cycle):
  - IDLE -> WRITE or READ on s_start. Captures addr=s_base and cnt=s_len.
  - WRITE: each cycle, m_mem_addr<=addr, m_mem_wdata<=s_wdata, m_mem_wvalid<=1, and s_wready=1.
    - cnt==0 -> DONE; otherwise addr++ and cnt--.
  - READ: each cycle, m_mem_addr<=addr, m_mem_wvalid<=0, and a token {valid=1, last=(cnt==0)} is pushed.
    - cnt==0 -> DRAIN.
  - DRAIN: wait until the token pipeline is empty -> DONE.
  - DONE: m_mem_wvalid<=0, m_done=1 for one cke cycle -> IDLE.
- Outside WRITE, m_mem_wvalid is 0.
- Address wraps modulo 2^ADDR_BITS; 7+1 -> 0.
- s_start while busy is ignored, with no queuing.
- s_start is accepted in IDLE on the same cycle that DONE->IDLE has just completed. Back-to-back bursts therefore incur a 2-cycle gap.
- Read alignment:
  - The token pipeline is LATENCY+1 cke stages, matching the registered m_mem_addr plus LATENCY memory stages.
  - m_rvalid/m_rlast come from the last stage.
  - First m_rvalid occurs LATENCY+2 cke cycles after s_start is accepted.
- Write-then-read of the same address is legal in consecutive bursts. Read data reflects the write, since the memory is read-after-write coherent across cycles.
- Length arithmetic is unsigned LEN_BITS. A burst longer than 2^ADDR_BITS words wraps and rewrites or re-reads from s_base.

Optional Feature:
- Macro ELIXIRCHIP_ES1_SPU_OP_MEM_CTL_STRIDE_EN.
- Defined:
  - Adds input port s_stride (ADDR_BITS), captured with s_start.
  - Address step is addr += stride, modulo 2^ADDR_BITS.
  - stride=0 repeatedly accesses s_base.
- Undefined: no s_stride port; step is fixed at 1.

Decomposition:
- Package elixirchip_es1_spu_op_mem_ctl_pkg contains:
  - state_t enum {IDLE, WRITE, READ, DRAIN, DONE};
  - token_t struct {valid, last};
  - function next_addr(addr, step).
- Sub-module elixirchip_es1_spu_op_mem_ctl_token_pipe: DEPTH-stage cke-gated shift register of token_t, with async reset and an empty flag.
- Memory instance stays outside; the bench connects the two.

Test Plan:
- Write then read, LATENCY=3, ADDR_BITS=3, DATA_BITS=8.
  - Stimulus: write base=0, len=7, data 0x10..0x17; then read base=0, len=7.
  - Response: m_rdata 0x10..0x17 in order, m_rlast only on 0x17, one m_done per burst, first m_rvalid 5 cycles after read start.
- Wrap: write base=6, len=3, data 0xA0..0xA3; read base=0, len=1 -> 0xA2, 0xA3.
- cke gaps: same read burst with cke=0 inserted at words 2 and 5 -> identical data sequence, m_rvalid never 1 while cke=0, no duplicated or lost words.
- Busy rejection: s_start (write base=3) pulsed during a read burst -> ignored; no m_mem_wvalid, and the address-3 contents are unchanged on a later read.
- Reset mid-read (async, after 3 of 8 addresses) -> outputs immediately 0, no m_rvalid afterwards, next read of base=4, len=0 returns the stored value.
- With STRIDE_EN: read base=1, len=3, stride=3 -> addresses 1, 4, 7, 2 on m_mem_addr.

Source files
------------

// File: rtl/elixirchip_es1_spu_op_mem_ctl_pkg.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_mem_ctl_pkg
// Shared types and helpers for the SPU single-port memory burst controller.
//   state_t   : controller FSM encoding
//   token_t   : read-alignment token carried alongside each issued read address
//   next_addr : address step helper; the caller truncates the result to its
//               address width, which gives modulo-2^ADDR_BITS wrap for free
// -----------------------------------------------------------------------------
package elixirchip_es1_spu_op_mem_ctl_pkg;

    localparam int ADDR_W_MAX = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } token_t;

    function automatic logic [ADDR_W_MAX-1:0] next_addr(
        input logic [ADDR_W_MAX-1:0] addr,
        input logic [ADDR_W_MAX-1:0] step
    );
        return addr + step;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_mem_ctl_token_pipe.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_mem_ctl_token_pipe
// DEPTH-stage shift register of read tokens, advanced only when cke_i is high.
// Each stage mirrors one cycle of the address/memory read path so the tail
// token lines up with the memory's read data.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears every stage)
//   cke_i      : clock enable; 0 freezes the pipeline
//   push_i     : token entering stage 0 (valid=0 inserts a bubble)
//   tail_o     : token in the last stage
//   empty_o    : 1 when no stage holds a valid token
// -----------------------------------------------------------------------------
module elixirchip_es1_spu_op_mem_ctl_token_pipe
    import elixirchip_es1_spu_op_mem_ctl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   cke_i,
    input  token_t push_i,
    output token_t tail_o,
    output logic   empty_o
);

    token_t stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (cke_i) begin
            stage_q[0] <= push_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_q[i].valid) begin
                empty_o = 1'b0;
            end
        end
    end

    assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/elixirchip_es1_spu_op_mem_ctl.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_mem_ctl
// Initiator-side burst controller for one elixirchip_es1_spu_op_mem_sp
// instance. Turns one command (base, length, direction) into a per-cycle
// address / write-data sequence and realigns the memory's LATENCY-delayed
// read data into a valid/last stream.
//
// Optional feature: define ELIXIRCHIP_ES1_SPU_OP_MEM_CTL_STRIDE_EN to add the
// s_stride input (captured with s_start); otherwise the address step is 1.
//
// Ports:
//   reset, clk, cke        : async active-high reset, clock, clock enable
//   s_start/s_write/s_base/s_len : command; accepted only in IDLE
//   s_busy                 : high whenever the FSM is not IDLE
//   s_wdata/s_wready       : write stream
//   m_mem_addr/m_mem_wdata/m_mem_wvalid : registered memory request
//   s_mem_rdata            : memory read data
//   m_rdata/m_rvalid/m_rlast : read stream
//   m_done                 : one-cycle pulse at burst completion
//
// Handshake semantics: every strobe output (s_wready, m_rvalid, m_rlast,
// m_done) is qualified with cke, so each event is visible on exactly one clock
// on which cke=1. s_wready=1 means s_wdata is consumed at the coming edge; the
// write stream has no valid of its own, the source must present the next word
// whenever s_wready can be asserted. m_rvalid has no backpressure: the
// consumer must accept every word on the cycle it is presented.
// -----------------------------------------------------------------------------
module elixirchip_es1_spu_op_mem_ctl
    import elixirchip_es1_spu_op_mem_ctl_pkg::*;
#(
    parameter int    LATENCY    = 3,
    parameter int    DATA_BITS  = 8,
    parameter int    ADDR_BITS  = 3,
    parameter int    LEN_BITS   = 8,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 cke,

    input  logic                 s_start,
    input  logic                 s_write,
    input  logic [ADDR_BITS-1:0] s_base,
    input  logic [LEN_BITS-1:0]  s_len,
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_CTL_STRIDE_EN
    input  logic [ADDR_BITS-1:0] s_stride,
`endif
    output logic                 s_busy,

    input  logic [DATA_BITS-1:0] s_wdata,
    output logic                 s_wready,

    output logic [ADDR_BITS-1:0] m_mem_addr,
    output logic [DATA_BITS-1:0] m_mem_wdata,
    output logic                 m_mem_wvalid,
    input  logic [DATA_BITS-1:0] s_mem_rdata,

    output logic [DATA_BITS-1:0] m_rdata,
    output logic                 m_rvalid,
    output logic                 m_rlast,
    output logic                 m_done
);

    // Elaboration-time parameter sanity checks.
    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("LATENCY must be 1..3");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > ADDR_W_MAX) begin : g_bad_addr_bits
        $error("ADDR_BITS out of range");
    end
    if (DEVICE == "") begin : g_bad_device
        $error("DEVICE must not be empty");
    end
    if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_simulation
        $error("SIMULATION must be \"true\" or \"false\"");
    end
    if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
        $error("DEBUG must be \"true\" or \"false\"");
    end

    state_t               state_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  cnt_q;
    logic [ADDR_BITS-1:0] m_mem_addr_q;
    logic [DATA_BITS-1:0] m_mem_wdata_q;
    logic                 m_mem_wvalid_q;

    logic [ADDR_BITS-1:0] step;
    logic [ADDR_BITS-1:0] addr_d;

`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_CTL_STRIDE_EN
    logic [ADDR_BITS-1:0] step_q;
    assign step = step_q;
`else
    assign step = ADDR_BITS'(1);
`endif

    // Truncating the wide sum wraps the address modulo 2^ADDR_BITS.
    assign addr_d = ADDR_BITS'(next_addr(ADDR_W_MAX'(addr_q), ADDR_W_MAX'(step)));

    // One token per issued read address; it walks the pipe in lockstep with
    // the registered address and the memory's LATENCY read stages.
    token_t push_tok;
    token_t tail_tok;
    logic   pipe_empty;

    always_comb begin
        push_tok       = '0;
        push_tok.valid = (state_q == READ);
        push_tok.last  = (state_q == READ) && (cnt_q == '0);
    end

    elixirchip_es1_spu_op_mem_ctl_token_pipe #(
        .DEPTH (LATENCY + 1)
    ) u_token_pipe (
        .clk     (clk),
        .reset   (reset),
        .cke_i   (cke),
        .push_i  (push_tok),
        .tail_o  (tail_tok),
        .empty_o (pipe_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            cnt_q          <= '0;
            m_mem_addr_q   <= '0;
            m_mem_wdata_q  <= '0;
            m_mem_wvalid_q <= 1'b0;
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_CTL_STRIDE_EN
            step_q         <= '0;
`endif
        end else if (cke) begin
            case (state_q)
                IDLE: begin
                    m_mem_wvalid_q <= 1'b0;
                    if (s_start) begin
                        state_q <= s_write ? WRITE : READ;
                        addr_q  <= s_base;
                        cnt_q   <= s_len;
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_CTL_STRIDE_EN
                        step_q  <= s_stride;
`endif
                    end
                end
                WRITE: begin
                    m_mem_addr_q   <= addr_q;
                    m_mem_wdata_q  <= s_wdata;
                    m_mem_wvalid_q <= 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q - LEN_BITS'(1);
                    end
                end
                READ: begin
                    m_mem_addr_q   <= addr_q;
                    m_mem_wvalid_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q - LEN_BITS'(1);
                    end
                end
                DRAIN: begin
                    m_mem_wvalid_q <= 1'b0;
                    // The last token has left the tail, so its data was delivered.
                    if (pipe_empty) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    m_mem_wvalid_q <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    m_mem_wvalid_q <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    assign s_busy       = (state_q != IDLE);
    assign s_wready     = cke && (state_q == WRITE);
    assign m_mem_addr   = m_mem_addr_q;
    assign m_mem_wdata  = m_mem_wdata_q;
    assign m_mem_wvalid = m_mem_wvalid_q;
    assign m_rdata      = s_mem_rdata;
    assign m_rvalid     = cke && tail_tok.valid;
    assign m_rlast      = cke && tail_tok.valid && tail_tok.last;
    assign m_done       = cke && (state_q == DONE);

endmodule
